// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU front-end control blocks.
package cpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HAZARD   = 2'd2,
    ST_MEM_WAIT = 2'd3
  } pcseq_state_t;

  localparam int unsigned PC_STEP  = 32'd4;
  localparam int unsigned PC_RESET = 32'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and synchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         clr_ni,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  // Count up on enable, holding once every bit is set.
  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      r_cnt <= '0;
    end else if (inc_i && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pc_sequencer.sv
// Resolves start gating, load-use hazards, memory stalls and taken branches
// into the next PC, PC write enable and IF/ID, ID/EX strobes.
module pc_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             load_use_i,
  input  logic             mem_stall_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  output logic             pc_write_o,
  output logic [XLEN-1:0]  next_pc_o,
  output logic             if_id_write_o,
  output logic             if_id_flush_o,
  output logic             id_ex_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  pcseq_state_t    state_q, state_d;
  logic [XLEN-1:0] redirect_q, redirect_d;
  logic            pending_q, pending_d;
  logic            w_stall_inc;

  // State, redirect capture and pending flag.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      redirect_q <= XLEN'(PC_RESET);
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect_d;
      pending_q  <= pending_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    pc_write_o     = 1'b1;
    next_pc_o      = pc_i + XLEN'(PC_STEP);
    if_id_write_o  = 1'b1;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    state_d        = state_q;
    redirect_d     = redirect_q;
    pending_d      = pending_q;

    if ((state_q == ST_IDLE) || !start_i) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      pending_d      = 1'b0;
      state_d        = start_i ? ST_RUN : ST_IDLE;
    end else if (mem_stall_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      state_d       = ST_MEM_WAIT;
      // A branch arriving with the stall is replayed on release.
      if ((state_q != ST_MEM_WAIT) && branch_taken_i) begin
        redirect_d = branch_target_i;
        pending_d  = 1'b1;
      end else begin
        redirect_d = redirect_q;
      end
    end else if ((state_q == ST_MEM_WAIT) && pending_q) begin
      next_pc_o     = redirect_q;
      if_id_flush_o = 1'b1;
      pending_d     = 1'b0;
      state_d       = ST_RUN;
    end else if (branch_taken_i) begin
      next_pc_o     = branch_target_i;
      if_id_flush_o = 1'b1;
      state_d       = ST_RUN;
    end else if (load_use_i && (state_q != ST_HAZARD)) begin
      pc_write_o     = 1'b0;
      if_id_write_o  = 1'b0;
      id_ex_bubble_o = 1'b1;
      state_d        = ST_HAZARD;
    end else begin
      state_d = ST_RUN;
    end
  end

  assign w_stall_inc = (state_q != ST_IDLE) && !pc_write_o;

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk_i),
    .clr_ni (rst_i),
    .inc_i  (w_stall_inc),
    .cnt_o  (stall_cnt_o)
  );

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Controller that sequences the program counter and IF/ID front end of the pipelined CPU. Each cycle it resolves start gating, load-use hazards, data-memory stalls and taken branches into one next-PC value, the PC write enable and the IF/ID and ID/EX control strobes. It sits beside the PC register and drives that register's write-enable and next-value inputs. It also keeps a saturating stall-cycle counter for performance reporting.

## Interface
- `XLEN`, 32: PC / address width.
- `CNT_W`, 32: width of the stall counter.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-low; one clock, synchronous active-low reset.
- `start_i` in 1: run enable; 0 holds the front end idle.
- `pc_i` in XLEN: current PC register value.
- `load_use_i` in 1: load-use hazard detected in ID.
- `mem_stall_i` in 1: data memory busy; the whole pipeline must freeze.
- `branch_taken_i` in 1: branch or jump in ID resolved taken.
- `branch_target_i` in XLEN: target address for a taken branch.
- `pc_write_o` out 1: PC register write enable.
- `next_pc_o` out XLEN: value loaded into the PC when `pc_write_o` = 1.
- `if_id_write_o` out 1: IF/ID register write enable.
- `if_id_flush_o` out 1: zero the IF/ID register (squash the fetched instruction).
- `id_ex_bubble_o` out 1: insert a NOP into ID/EX.
- `stall_cnt_o` out CNT_W: saturating count of frozen-PC cycles.

## Operation
- States: IDLE, RUN, HAZARD, MEM_WAIT.
- Registers:
  - `state_q`
  - `redirect_q` [XLEN]
  - `pending_q`
  - `stall_cnt_q`
- Output defaults, unless a rule below overrides them:
  - `pc_write_o`=1, `next_pc_o`=`pc_i`+4 (mod 2^XLEN, wraps silently)
  - `if_id_write_o`=1
  - `if_id_flush_o`=0, `id_ex_bubble_o`=0
- IDLE:
  - Outputs: `pc_write_o`=0, `if_id_write_o`=0, `id_ex_bubble_o`=1.
  - `start_i`=1 → RUN.
- RUN, inputs resolved in priority order:
  1. `mem_stall_i`=1: `pc_write_o`=0, `if_id_write_o`=0. If `branch_taken_i`=1 in the same cycle, capture `branch_target_i` into `redirect_q` and set `pending_q`. Next state MEM_WAIT.
  2. `branch_taken_i`=1: `next_pc_o`=`branch_target_i`, `if_id_flush_o`=1. Stay in RUN.
  3. `load_use_i`=1: `pc_write_o`=0, `if_id_write_o`=0, `id_ex_bubble_o`=1. Next state HAZARD.
- HAZARD: same rules as RUN, except `load_use_i` is ignored, so at most one bubble is inserted per hazard. With no stall, next state RUN.
- MEM_WAIT:
  - While `mem_stall_i`=1: `pc_write_o`=0, `if_id_write_o`=0, `id_ex_bubble_o`=0 (full freeze). `branch_taken_i` is ignored.
  - Release cycle (`mem_stall_i`=0):
    - If `pending_q`=1: `next_pc_o`=`redirect_q`, `if_id_flush_o`=1, clear `pending_q`.
    - Otherwise apply RUN rules 2–3.
  - Next state RUN, or HAZARD if the load-use rule fired.
- `start_i`=0 in any non-IDLE state:
  - IDLE outputs apply that same cycle.
  - Next state IDLE.
  - `pending_q` cleared.
  - `stall_cnt_q` retained.
- Stall counter:
  - `stall_cnt_q` increments when `state_q`≠IDLE and `pc_write_o`=0.
  - Saturates at 2^CNT_W−1.
  - Counts only frozen-PC cycles; branch flushes are not counted.

## Timing
- Outputs are combinational from `state_q`, `pending_q`, `redirect_q` and the current inputs; zero-cycle latency to the PC register.
- State, `redirect_q`, `pending_q` and `stall_cnt_q` update on the rising edge of `clk_i`.
- Reset (`rst_i`=0 at an edge) has priority over everything, including mid-MEM_WAIT with a redirect pending. It sets:
  - `state_q`=IDLE, `pending_q`=0, `redirect_q`=0, `stall_cnt_q`=0.
- Outputs during and after reset, until `start_i`=1: `pc_write_o`=0, `if_id_write_o`=0, `if_id_flush_o`=0, `id_ex_bubble_o`=1, `stall_cnt_o`=0. `next_pc_o`=`pc_i`+4 (don't-care while `pc_write_o`=0).
- First PC advance happens in the cycle after the edge that samples `start_i`=1.
- Simultaneous `mem_stall_i` + `load_use_i`: the stall wins. The hazard is re-evaluated in the release cycle.

## Structure
- Shared package `cpu_ctrl_pkg`:
  - State enum `pcseq_state_t`
  - `PC_STEP` = 4
  - `PC_RESET` = 0
- One natural sub-module: `sat_counter` (parameterised width, increment enable, synchronous active-low clear); reusable for the other performance counters.
- The remaining next-state and output logic is one flat always-block pair in `pc_sequencer`.

## Test plan
- Reset then `start_i`=1 at cycle 2, `pc_i`=0x0 → `pc_write_o`=1 and `next_pc_o`=0x4 from cycle 3; `stall_cnt_o`=0.
- RUN, `pc_i`=0x10, `load_use_i` held high 2 cycles → exactly one cycle with `pc_write_o`=0 and `id_ex_bubble_o`=1, then `next_pc_o`=0x14; `stall_cnt_o`=1.
- `pc_i`=0x20, `branch_taken_i`=1, target 0x100 → `next_pc_o`=0x100, `if_id_flush_o`=1, `pc_write_o`=1 in the same cycle.
- `mem_stall_i`=1 with `branch_taken_i`=1, target 0x200, then 3 more stall cycles:
  - `pc_write_o`=0 for all 4 cycles.
  - Release cycle: `next_pc_o`=0x200, `if_id_flush_o`=1.
  - `stall_cnt_o` +4.
- Reset asserted in the 2nd MEM_WAIT cycle with a redirect pending → IDLE, `pending_q`=0, `stall_cnt_o`=0. After restart with `pc_i`=0x8: `next_pc_o`=0xC, no flush.
- `pc_i`=0xFFFFFFFC, no events → `next_pc_o`=0x0. With CNT_W=4 and 20 stall cycles → `stall_cnt_o` holds 0xF.
